// File: rtl/data_pack_stream_if.sv
// Sparse-in / dense-out streaming bus for data_pack_stream.
// Valid/ready rule on both sides: a beat moves on a rising edge where valid and ready are both high; a producer holding valid keeps its payload stable until that edge.
interface data_pack_stream_if #(
  parameter int DW = 32,
  parameter int N  = 8
);
  logic [DW-1:0] i_data [N-1:0];
  logic [N-1:0]  i_mask;
  logic          i_valid;
  logic          i_last;
  logic          o_ready;
  logic [DW-1:0] o_data [N-1:0];
  logic [N-1:0]  o_mask;
  logic          o_valid;
  logic          o_last;
  logic          i_ready;

  modport slave (
    input  i_data, i_mask, i_valid, i_last, i_ready,
    output o_ready, o_data, o_mask, o_valid, o_last
  );

  modport master (
    output i_data, i_mask, i_valid, i_last, i_ready,
    input  o_ready, o_data, o_mask, o_valid, o_last
  );
endinterface

// File: rtl/data_pack_stream.sv
// Streaming lane compactor: sparse masked beats are packed into a residue buffer
// and emitted as dense N-lane words; a packet end flushes the partial remainder.
module data_pack_stream #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  data_pack_stream_if.slave    s,
  output logic                 dbg_state_o,
  output logic [$clog2(N):0]   dbg_cnt_o
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_TAIL = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] res_q [N-1:0];
  logic [DW-1:0] res_d [N-1:0];
  logic [DW-1:0] out_data_q [N-1:0];
  logic [DW-1:0] out_data_d [N-1:0];
  logic [N-1:0]  out_mask_q, out_mask_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  // Staging holds residue followed by the compacted beat; top lane never used.
  logic [DW-1:0] stage [2*N-1:0];
  logic [CW-1:0] tot;
  logic          in_fire, out_fire;

  function automatic logic [N-1:0] thermo(input logic [CW-1:0] n);
    logic [N-1:0] t;
    for (int j = 0; j < N; j++) t[j] = (CW'(j) < n);
    return t;
  endfunction

  assign s.o_ready = (state_q == ST_RUN) & (~out_valid_q | s.i_ready);
  assign in_fire   = s.i_valid & s.o_ready;
  assign out_fire  = out_valid_q & s.i_ready;

  always_comb begin
    for (int j = 0; j < 2*N; j++) stage[j] = '0;
    for (int j = 0; j < N; j++) begin
      if (CW'(j) < cnt_q) stage[j] = res_q[j];
    end
    tot = cnt_q;
    for (int k = 0; k < N; k++) begin
      if (s.i_mask[k]) begin
        stage[tot] = s.i_data[k];
        tot        = tot + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_mask_d  = '0;
      out_last_d  = 1'b0;
      for (int j = 0; j < N; j++) out_data_d[j] = '0;
    end

    if (state_q == ST_TAIL) begin
      // The held full word is leaving; the leftover lanes become the final beat.
      if (out_fire) begin
        for (int j = 0; j < N; j++) begin
          out_data_d[j] = (CW'(j) < cnt_q) ? res_q[j] : '0;
          res_d[j]      = '0;
        end
        out_mask_d  = thermo(cnt_q);
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_RUN;
      end
    end else if (in_fire) begin
      if (tot < CW'(N)) begin
        if (!s.i_last) begin
          cnt_d = tot;
          for (int j = 0; j < N; j++) res_d[j] = stage[j];
        end else begin
          for (int j = 0; j < N; j++) begin
            out_data_d[j] = stage[j];
            res_d[j]      = '0;
          end
          out_mask_d  = thermo(tot);
          out_last_d  = 1'b1;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end else begin
        for (int j = 0; j < N; j++) begin
          out_data_d[j] = stage[j];
          res_d[j]      = stage[N+j];
        end
        out_mask_d  = '1;
        out_valid_d = 1'b1;
        cnt_d       = tot - CW'(N);
        out_last_d  = 1'b0;
        if (s.i_last) begin
          if (tot == CW'(N)) out_last_d = 1'b1;
          else               state_d    = ST_TAIL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int j = 0; j < N; j++) begin
        res_q[j]      <= '0;
        out_data_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign s.o_data     = out_data_q;
  assign s.o_mask     = out_mask_q;
  assign s.o_valid    = out_valid_q;
  assign s.o_last     = out_last_q;
  assign dbg_state_o  = state_q;
  assign dbg_cnt_o    = cnt_q;
endmodule

// File: doc/data_pack_stream.md
Name: data_pack_stream

Overview:
- Streaming successor to the single-cycle lane compactor.
- Each accepted beat of N sparse lanes is compacted so its valid lanes become contiguous. These lanes are appended to a residue buffer carried across beats.
- A dense N-lane word is emitted whenever N lanes have accumulated. A packet end (i_last) flushes the partial remainder.
- Both sides use valid/ready handshakes. The block sits between sparse producers (filters/selectors) and dense consumers (packers, FIFOs, DMA).

Parameters:
- DW, 32, lane data width in bits
- N, 8, lanes per beat; power of two, N >= 2

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- i_data  input  DW x N (unpacked [N-1:0])  input lanes
- i_mask  input  N  per-lane valid; any pattern, including all-zero
- i_valid  input  1  input beat valid
- i_last  input  1  beat is last of packet
- o_ready  output  1  block accepts an input beat this cycle
- o_data  output  DW x N (unpacked [N-1:0])  dense output lanes, lane 0 = oldest
- o_mask  output  N  output lane valid; always a thermometer code (low lanes set)
- o_valid  output  1  output beat valid
- o_last  output  1  output beat ends packet
- i_ready  input  1  downstream accepts output beat

Behaviour:
- Reset (rst=1 at an edge):
  - o_valid=0, o_last=0, o_mask=0, o_data=0.
  - Residue count cnt=0, state=RUN.
  - Reset mid-packet discards residue and the held output. No output beat is produced for the discarded data.
- Handshakes:
  - Input transfer = i_valid & o_ready. Output transfer = o_valid & i_ready.
  - o_valid/o_data/o_mask/o_last hold stable while o_valid=1 and i_ready=0.
- o_ready = (state==RUN) & (!o_valid | i_ready). This is combinational from i_ready; there is no combinational path from i_valid.
- Compaction:
  - pop = popcount(i_mask).
  - A masked lane k is placed at compacted position prefix(k) = sum of i_mask[0..k-1].
  - Relative lane order is preserved. The appended position is cnt + prefix(k). Residue is a 2N-1 lane staging area; cnt ranges 0..N-1.
- On input transfer in RUN, with tot = cnt + pop:
  - tot < N and i_last=0: no output; cnt <= tot.
  - tot < N and i_last=1: emit tot lanes with o_mask = thermometer(tot) and o_last=1; cnt <= 0. tot=0 emits an empty beat (o_mask=0, o_last=1) so packet boundaries are never lost.
  - tot >= N and i_last=0: emit lanes 0..N-1 with o_mask all-ones and o_last=0. Lanes N..tot-1 shift down to residue 0..; cnt <= tot-N.
  - tot == N and i_last=1: emit full word with o_last=1; cnt <= 0.
  - tot > N and i_last=1: emit full word with o_last=0; cnt <= tot-N; state <= TAIL.
- TAIL state:
  - o_ready=0.
  - On output transfer of the held word, load residue as the next output beat: o_mask = thermometer(cnt), o_last=1. Then cnt <= 0 and state <= RUN.
- Latency: exactly 1 cycle from input transfer to the o_valid assertion it causes.
- Throughput: 1 beat/cycle sustained with i_ready=1. Each tot>N & i_last beat costs one extra cycle.
- Empty output lanes (o_mask bit 0) drive 0.
- Input beats with i_valid=0 never alter state, even if i_mask/i_last toggle.
- Residue persists across idle cycles and across input bubbles. Across packets it is always empty, because every packet ends with a flush.
- Width rules:
  - cnt and positions are $clog2(N)+1 bits wide.
  - tot max = 2N-1 fits without overflow.

Test Plan (N=4, DW=8):
- Single sparse beat: mask 4'b1010, data {d3=0x33,d2=0x22,d1=0x11,d0=0x00}, last=1 -> next cycle o_data lanes {0,0,0x33,0x11}, o_mask 4'b0011, o_last=1, cnt=0.
- Accumulate: beats mask 4'b0011 (A,B), 4'b0110 (C,D), last on the second -> one output {D,C,B,A}, o_mask 4'b1111, o_last=1; no output after the first beat.
- Overflow to TAIL: cnt=3 (A,B,C), then beat mask 4'b1111 (E,F,G,H) last=1 -> out1 {E,C,B,A} o_last=0, o_ready=0 next cycle; out2 {0,H,G,F} o_mask 4'b0111 o_last=1; then RUN.
- Backpressure: hold i_ready=0 for 5 cycles with output pending -> o_ready=0, output stable; continuous input after release -> no lane lost or duplicated over 64 random beats (scoreboard vs software compactor).
- Empty last: cnt=0, mask 4'b0000, last=1 -> o_valid=1, o_mask=0, o_last=1, o_data=0.
- Reset mid-packet: cnt=2 and output held, assert rst one cycle -> o_valid=0, cnt=0; next packet mask 4'b1111 last=1 outputs only the new lanes.
